// File: rtl/crossbar_ctl_if.sv
// Request/crossbar bus for crossbar_ctl: per-requester request lanes plus the
// registered crossbar write port and status.
interface crossbar_ctl_if #(
  parameter int unsigned W = 3,
  parameter int unsigned M = 4,
  parameter int unsigned R = 4
);
  logic [R-1:0]   req;
  logic [R*W-1:0] from_i;
  logic [R*W-1:0] to_i;
  logic [R-1:0]   ack;
  logic [R-1:0]   nak;
  logic [W-1:0]   cb_from;
  logic [W-1:0]   cb_to;
  logic           cb_put;
  logic [M-1:0]   active;
  logic           busy;

  modport master (
    output req, from_i, to_i,
    input  ack, nak, cb_from, cb_to, cb_put, active, busy
  );

  modport slave (
    input  req, from_i, to_i,
    output ack, nak, cb_from, cb_to, cb_put, active, busy
  );
endinterface

// File: rtl/crossbar_ctl.sv
// Round-robin crossbar subscription controller: one validated put per GAP+3 cycles.
// Define CROSSBAR_CTL_OWNER_EN to track a per-output owner and refuse foreign changes.
module crossbar_ctl #(
  parameter int unsigned W   = 3,
  parameter int unsigned N   = 4,
  parameter int unsigned M   = 4,
  parameter int unsigned R   = 4,
  parameter int unsigned GAP = 2
) (
  input  logic          clock,
  input  logic          reset,
  crossbar_ctl_if.slave bus
);

  localparam int unsigned RW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StIssue, StHold} state_e;

  state_e         state_q, state_d;
  logic [RW-1:0]  ptr_q, ptr_d;
  logic [RW-1:0]  win_q, win_d;
  logic [W-1:0]   from_q, from_d;
  logic [W-1:0]   to_q, to_d;
  logic           ok_q, ok_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [R-1:0]   ack_q, ack_d;
  logic [R-1:0]   nak_q, nak_d;
  logic [W-1:0]   cbf_q, cbf_d;
  logic [W-1:0]   cbt_q, cbt_d;
  logic           put_q, put_d;
  logic [M-1:0]   active_q, active_d;
`ifdef CROSSBAR_CTL_OWNER_EN
  logic [M-1:0]   owned_q, owned_d;
  logic [RW-1:0]  owner_q [M];
  logic [RW-1:0]  owner_d [M];
`endif

  logic [W-1:0] from_arr [R];
  logic [W-1:0] to_arr   [R];

  for (genvar g = 0; g < int'(R); g++) begin : g_slice
    assign from_arr[g] = bus.from_i[g*W +: W];
    assign to_arr[g]   = bus.to_i[g*W +: W];
  end

  // Round-robin search starting at ptr_q.
  logic          found;
  logic [RW-1:0] pick;

  always_comb begin
    int idx;
    logic [RW-1:0] idx_b;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_b = '0;
    for (int k = 0; k < int'(R); k++) begin
      idx   = (int'(ptr_q) + k) % int'(R);
      idx_b = RW'(idx);
      if (!found && bus.req[idx_b]) begin
        found = 1'b1;
        pick  = idx_b;
      end
    end
  end

  always_comb begin
    int   to_v;
    int   from_v;
    logic unsub;
    logic refuse;

    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    from_d   = from_q;
    to_d     = to_q;
    ok_d     = ok_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    nak_d    = '0;
    cbf_d    = cbf_q;
    cbt_d    = cbt_q;
    put_d    = 1'b0;
    active_d = active_q;
`ifdef CROSSBAR_CTL_OWNER_EN
    owned_d  = owned_q;
    owner_d  = owner_q;
`endif
    to_v     = int'($signed(to_arr[win_q]));
    from_v   = int'($signed(from_arr[win_q]));
    // A normalised unsubscribe is the only source code that is all ones.
    unsub    = &from_q;
    refuse   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          ptr_d   = RW'((int'(pick) + 1) % int'(R));
          state_d = StGrant;
        end
      end

      StGrant: begin
        refuse = (to_v < 0) || (to_v >= int'(M));
`ifdef CROSSBAR_CTL_OWNER_EN
        for (int m = 0; m < int'(M); m++) begin
          if (m == to_v && owned_q[m] && owner_q[m] != win_q) refuse = 1'b1;
        end
`endif
        from_d  = ((from_v < 0) || (from_v >= int'(N))) ? '1 : from_arr[win_q];
        to_d    = to_arr[win_q];
        ok_d    = !refuse;
        state_d = StIssue;
      end

      StIssue: begin
        if (ok_q) begin
          put_d        = 1'b1;
          cbf_d        = from_q;
          cbt_d        = to_q;
          ack_d[win_q] = 1'b1;
          for (int m = 0; m < int'(M); m++) begin
            if (int'(to_q) == m) begin
              active_d[m] = !unsub;
`ifdef CROSSBAR_CTL_OWNER_EN
              if (!unsub) begin
                owned_d[m] = 1'b1;
                owner_d[m] = win_q;
              end else if (owned_q[m] && owner_q[m] == win_q) begin
                owned_d[m] = 1'b0;
              end
`endif
            end
          end
        end else begin
          nak_d[win_q] = 1'b1;
        end
        cnt_d   = '0;
        state_d = StHold;
      end

      StHold: begin
        if (int'(cnt_q) + 1 >= int'(GAP)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      from_q   <= '1;
      to_q     <= '0;
      ok_q     <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      nak_q    <= '0;
      cbf_q    <= '1;
      cbt_q    <= '0;
      put_q    <= 1'b0;
      active_q <= '0;
`ifdef CROSSBAR_CTL_OWNER_EN
      owned_q  <= '0;
      for (int m = 0; m < int'(M); m++) owner_q[m] <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      from_q   <= from_d;
      to_q     <= to_d;
      ok_q     <= ok_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      nak_q    <= nak_d;
      cbf_q    <= cbf_d;
      cbt_q    <= cbt_d;
      put_q    <= put_d;
      active_q <= active_d;
`ifdef CROSSBAR_CTL_OWNER_EN
      owned_q  <= owned_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign bus.ack     = ack_q;
  assign bus.nak     = nak_q;
  assign bus.cb_from = cbf_q;
  assign bus.cb_to   = cbt_q;
  assign bus.cb_put  = put_q;
  assign bus.active  = active_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_crossbar_ctl.sv
// Directed bench for crossbar_ctl: vector table of single requests plus
// round-robin, reset-abort and (with CROSSBAR_CTL_OWNER_EN) ownership sequences.
module tb_crossbar_ctl;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nerr;
  int   cyc;

  crossbar_ctl_if #(.W(3), .M(4), .R(4)) bus ();

  crossbar_ctl #(.W(3), .N(4), .M(4), .R(4), .GAP(2)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         r;
    logic [2:0] f;
    logic [2:0] t;
    logic [3:0] e_ack;
    logic [3:0] e_nak;
    logic       e_put;
    logic [2:0] e_from;
    logic [2:0] e_to;
    logic [3:0] e_act;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.from_i = '0;
    bus.to_i   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int i;
    bus.req    = '0;
    bus.from_i = '0;
    bus.to_i   = '0;
    bus.req[v.r]          = 1'b1;
    bus.from_i[v.r*3 +: 3] = v.f;
    bus.to_i[v.r*3 +: 3]   = v.t;
    i = 0;
    while ((bus.ack | bus.nak) == 4'b0 && i < 10) begin
      tick();
      i++;
    end
    check({v.name, " latency"}, i, 3);
    check({v.name, " ack"}, bus.ack, v.e_ack);
    check({v.name, " nak"}, bus.nak, v.e_nak);
    check({v.name, " cb_put"}, bus.cb_put, v.e_put);
    check({v.name, " cb_from"}, bus.cb_from, v.e_from);
    check({v.name, " cb_to"}, bus.cb_to, v.e_to);
    check({v.name, " active"}, bus.active, v.e_act);
    bus.req = '0;
    tick();
    check({v.name, " put pulse"}, {bus.cb_put, bus.ack, bus.nak}, 9'b0);
    check({v.name, " cb hold"}, {bus.cb_from, bus.cb_to}, {v.e_from, v.e_to});
    i = 0;
    while (bus.busy && i < 10) begin
      tick();
      i++;
    end
    check({v.name, " back to idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    int         i;
    int         last;
    logic       seen;
    logic [3:0] want;
    vec_t       v;

    ncmp = 0;
    nerr = 0;
    //          name   r  f     t     ack      nak      put   from  to    active
    vecs[0] = '{"sub00", 0, 3'd0, 3'd0, 4'b0001, 4'b0000, 1'b1, 3'd0, 3'd0, 4'b0001};
    vecs[1] = '{"sub11", 1, 3'd1, 3'd1, 4'b0010, 4'b0000, 1'b1, 3'd1, 3'd1, 4'b0011};
    vecs[2] = '{"unsub1", 1, 3'd6, 3'd1, 4'b0010, 4'b0000, 1'b1, 3'd7, 3'd1, 4'b0001};
    vecs[3] = '{"to5", 3, 3'd0, 3'd5, 4'b0000, 4'b1000, 1'b0, 3'd7, 3'd1, 4'b0001};
    vecs[4] = '{"sub33", 0, 3'd3, 3'd3, 4'b0001, 4'b0000, 1'b1, 3'd3, 3'd3, 4'b1001};
    vecs[5] = '{"unsub2", 1, 3'd5, 3'd2, 4'b0010, 4'b0000, 1'b1, 3'd7, 3'd2, 4'b1001};
    vecs[6] = '{"toneg", 2, 3'd4, 3'd7, 4'b0000, 4'b0100, 1'b0, 3'd7, 3'd2, 4'b1001};
`ifdef CROSSBAR_CTL_OWNER_EN
    vecs[7] = '{"foreign3", 3, 3'd0, 3'd3, 4'b0000, 4'b1000, 1'b0, 3'd7, 3'd2, 4'b1001};
`else
    vecs[7] = '{"foreign3", 3, 3'd0, 3'd3, 4'b1000, 4'b0000, 1'b1, 3'd0, 3'd3, 4'b1001};
`endif

    do_reset();
    check("reset busy", bus.busy, 1'b0);
    check("reset active", bus.active, 4'b0);
    check("reset cb_from", bus.cb_from, 3'b111);
    check("reset cb_to", bus.cb_to, 3'd0);
    check("reset put/ack/nak", {bus.cb_put, bus.ack, bus.nak}, 9'b0);

    for (int k = 0; k < 8; k++) apply(vecs[k]);

    // Reset while in GRANT: nothing is issued and shadow state clears.
    bus.req    = 4'b0001;
    bus.from_i = '0;
    bus.to_i   = 12'd2;
    tick();
    check("abort busy in grant", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("abort busy", bus.busy, 1'b0);
    check("abort active", bus.active, 4'b0);
    check("abort put/ack/nak", {bus.cb_put, bus.ack, bus.nak}, 9'b0);
    rst_n   = 1'b1;
    bus.req = '0;
    seen    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.cb_put || bus.ack != 4'b0 || bus.nak != 4'b0) seen = 1'b1;
    end
    check("abort no late put", seen, 1'b0);

    // All four request together; each drops on its ack.
    do_reset();
    bus.req    = 4'b1111;
    bus.from_i = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.to_i   = {3'd3, 3'd2, 3'd1, 3'd0};
    last       = 0;
    for (int g = 0; g < 4; g++) begin
      i = 0;
      while ((bus.ack | bus.nak) == 4'b0 && i < 12) begin
        tick();
        i++;
      end
      want = 4'b0001 << g;
      check($sformatf("rr grant %0d", g), bus.ack, want);
      check($sformatf("rr put %0d", g), bus.cb_put, 1'b1);
      if (g > 0) check($sformatf("rr spacing %0d", g), cyc - last, 5);
      last    = cyc;
      bus.req = bus.req & ~bus.ack;
      tick();
    end
    check("rr active", bus.active, 4'b1111);

`ifdef CROSSBAR_CTL_OWNER_EN
    do_reset();
    v = '{"own sub", 0, 3'd2, 3'd3, 4'b0001, 4'b0000, 1'b1, 3'd2, 3'd3, 4'b1000};
    apply(v);
    v = '{"own foreign", 1, 3'd1, 3'd3, 4'b0000, 4'b0010, 1'b0, 3'd2, 3'd3, 4'b1000};
    apply(v);
    v = '{"own unsub", 0, 3'd7, 3'd3, 4'b0001, 4'b0000, 1'b1, 3'd7, 3'd3, 4'b0000};
    apply(v);
    v = '{"own retry", 1, 3'd1, 3'd3, 4'b0010, 4'b0000, 1'b1, 3'd1, 3'd3, 4'b1000};
    apply(v);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
